// File: rtl/de10_multi_timer.sv
// de10_multi_timer
//   NUM_CH independent CNT_W-bit interval down-counters behind one 32-bit
//   Avalon-MM slave. Each channel has a prescaler, a one-shot or continuous
//   mode, a snapshot register and an interrupt. The channel interrupts are
//   OR-ed onto irq.
//
//   Address = {channel, reg[2:0]}; reg map per channel:
//     0 STATUS   bit0 TO, bit1 RUN (any write clears TO)
//     1 CONTROL  bit0 ITO, bit1 CONT, bit2 START / bit3 STOP (strobes)
//     2 PERIOD   write also forces a reload on the following cycle
//     3 SNAP     write captures COUNT, read returns the capture
//     4 PRESCALE tick = clk / (PRESCALE+1)
//     5 COUNT    live, read-only
//     6 reserved, reads 0
//     7 PEND     NUM_CH-bit vector of TO&ITO, same from every channel
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address {channel, reg}
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    registered read data (one cycle latency)
//   irq         OR over channels of TO & ITO
module de10_multi_timer #(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int          PRE_W        = 8,
    parameter int unsigned RESET_PERIOD = 999999,
    parameter int          AW           = $clog2(NUM_CH) + 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] address,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic          irq
);

    localparam int CHW = (AW > 3) ? AW - 3 : 1;
    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(RESET_PERIOD);

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_SNAP     = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;
    localparam logic [2:0] REG_COUNT    = 3'd5;
    localparam logic [2:0] REG_PEND     = 3'd7;

    logic [CNT_W-1:0] count_q    [NUM_CH];
    logic [CNT_W-1:0] count_d    [NUM_CH];
    logic [CNT_W-1:0] period_q   [NUM_CH];
    logic [CNT_W-1:0] period_d   [NUM_CH];
    logic [CNT_W-1:0] snap_q     [NUM_CH];
    logic [CNT_W-1:0] snap_d     [NUM_CH];
    logic [PRE_W-1:0] pre_q      [NUM_CH];
    logic [PRE_W-1:0] pre_d      [NUM_CH];
    logic [PRE_W-1:0] prescale_q [NUM_CH];
    logic [PRE_W-1:0] prescale_d [NUM_CH];

    logic [NUM_CH-1:0] to_q, to_d;
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] ito_q, ito_d;
    logic [NUM_CH-1:0] cont_q, cont_d;
    logic [NUM_CH-1:0] reload_q, reload_d;

    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] timeout;
    logic [NUM_CH-1:0] wr_ch;
    logic [NUM_CH-1:0] pend;

    logic [31:0]    readdata_q, readdata_d;
    logic [2:0]     reg_idx;
    logic [CHW-1:0] ch_idx;
    logic           ch_ok;
    logic           wr_en;

    // Channel field only exists when the address is wider than the reg field.
    if (AW > 3) begin : g_ch_field
        assign ch_idx = address[AW-1:3];
    end else begin : g_ch_single
        assign ch_idx = '0;
    end

    assign reg_idx = address[2:0];
    assign ch_ok   = (32'(ch_idx) < 32'(NUM_CH));
    assign wr_en   = chipselect & ~write_n;
    assign pend    = to_q & ito_q;
    assign irq     = |pend;
    assign readdata = readdata_q;

    // A forced reload suppresses the tick in that cycle: the reload owns COUNT.
    always_comb begin
        tick    = '0;
        timeout = '0;
        wr_ch   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            tick[c]    = run_q[c] && (pre_q[c] == '0) && !reload_q[c];
            timeout[c] = tick[c] && (count_q[c] == '0);
            wr_ch[c]   = wr_en && ch_ok && (ch_idx == CHW'(c));
        end
    end

    always_comb begin
        to_d     = to_q;
        run_d    = run_q;
        ito_d    = ito_q;
        cont_d   = cont_q;
        reload_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            count_d[c]    = count_q[c];
            period_d[c]   = period_q[c];
            snap_d[c]     = snap_q[c];
            pre_d[c]      = pre_q[c];
            prescale_d[c] = prescale_q[c];

            if (run_q[c] && !reload_q[c]) begin
                if (pre_q[c] == '0) begin
                    pre_d[c] = prescale_q[c];
                end else begin
                    pre_d[c] = pre_q[c] - PRE_W'(1);
                end
            end

            // Reload to PERIOD happens on the zero-count tick itself, so COUNT
            // never wraps to all-ones.
            if (tick[c]) begin
                if (count_q[c] == '0) begin
                    count_d[c] = period_q[c];
                    to_d[c]    = 1'b1;
                    if (!cont_q[c]) begin
                        run_d[c] = 1'b0;
                    end
                end else begin
                    count_d[c] = count_q[c] - CNT_W'(1);
                end
            end

            if (reload_q[c]) begin
                count_d[c] = period_q[c];
                run_d[c]   = 1'b0;
                pre_d[c]   = prescale_q[c];
            end

            // Bus writes are applied last so a START can override the reload's
            // RUN clear, and START beats STOP in the same write.
            if (wr_ch[c]) begin
                case (reg_idx)
                    REG_STATUS: to_d[c] = timeout[c];
                    REG_CONTROL: begin
                        ito_d[c]  = writedata[0];
                        cont_d[c] = writedata[1];
                        if (writedata[3]) begin
                            run_d[c] = 1'b0;
                        end
                        if (writedata[2]) begin
                            run_d[c] = 1'b1;
                            pre_d[c] = prescale_q[c];
                        end
                    end
                    REG_PERIOD: begin
                        period_d[c] = writedata[CNT_W-1:0];
                        reload_d[c] = 1'b1;
                    end
                    REG_SNAP:     snap_d[c]     = count_q[c];
                    REG_PRESCALE: prescale_d[c] = writedata[PRE_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        readdata_d = '0;
        if (ch_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == CHW'(c)) begin
                    case (reg_idx)
                        REG_STATUS:   readdata_d = {30'd0, run_q[c], to_q[c]};
                        REG_CONTROL:  readdata_d = {30'd0, cont_q[c], ito_q[c]};
                        REG_PERIOD:   readdata_d = 32'(period_q[c]);
                        REG_SNAP:     readdata_d = 32'(snap_q[c]);
                        REG_PRESCALE: readdata_d = 32'(prescale_q[c]);
                        REG_COUNT:    readdata_d = 32'(count_q[c]);
                        REG_PEND:     readdata_d = 32'(pend);
                        default:      readdata_d = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_q       <= '0;
            run_q      <= '0;
            ito_q      <= '0;
            cont_q     <= '0;
            reload_q   <= '0;
            readdata_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                count_q[c]    <= RST_PERIOD;
                period_q[c]   <= RST_PERIOD;
                snap_q[c]     <= '0;
                pre_q[c]      <= '0;
                prescale_q[c] <= '0;
            end
        end else begin
            to_q       <= to_d;
            run_q      <= run_d;
            ito_q      <= ito_d;
            cont_q     <= cont_d;
            reload_q   <= reload_d;
            readdata_q <= readdata_d;
            for (int c = 0; c < NUM_CH; c++) begin
                count_q[c]    <= count_d[c];
                period_q[c]   <= period_d[c];
                snap_q[c]     <= snap_d[c];
                pre_q[c]      <= pre_d[c];
                prescale_q[c] <= prescale_d[c];
            end
        end
    end

endmodule
